// File: rtl/intdiv_otf_conv_pkg.sv
// Shared definitions for the divider on-the-fly converter.
//  - SD2 digit/sign encodings (p,n), value = p - n
//  - FSM state encoding for intdiv_otf_conv
//  - sd2_is_zero(): true for either zero code
package intdiv_otf_conv_pkg;

  localparam logic [1:0] ZERO_1 = 2'b00;
  localparam logic [1:0] NEG1   = 2'b01;
  localparam logic [1:0] POS1   = 2'b10;
  localparam logic [1:0] ZERO_2 = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Both (0,0) and (1,1) mean zero.
  function automatic logic sd2_is_zero(input logic [1:0] d);
    return d[1] == d[0];
  endfunction

endpackage

// File: rtl/intdiv_otf_conv_cell.sv
// One on-the-fly conversion step: next Q / QM from the current pair and one
// SD2 digit. Q holds the converted prefix, QM holds Q - 1; a -1 digit then
// needs no borrow propagation because it selects from QM instead.
// Ports:
//  q, qm         in   N   current registers
//  digit         in   2   SD2 digit (either zero code is zero)
//  q_next        out  N   updated Q
//  qm_next       out  N   updated QM
module intdiv_otf_conv_cell
  import intdiv_otf_conv_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [N-1:0] q,
  input  logic [N-1:0] qm,
  input  logic [1:0]   digit,
  output logic [N-1:0] q_next,
  output logic [N-1:0] qm_next
);

  // NOTE: every output gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    q_next  = {q[N-2:0], 1'b0};
    qm_next = {qm[N-2:0], 1'b1};
    if (digit == POS1) begin
      q_next  = {q[N-2:0], 1'b1};
      qm_next = {q[N-2:0], 1'b0};
    end else if (digit == NEG1) begin
      q_next  = {qm[N-2:0], 1'b1};
      qm_next = {qm[N-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/intdiv_otf_conv.sv
// On-the-fly converter for the divider back end. Consumes an MSB-first SD2
// magnitude digit stream and builds the nonnegative binary magnitude in Q/QM
// without a final carry-propagate addition. Also registers the quotient sign.
// Ports:
//  clk, rst_n     clock, asynchronous active-low reset
//  start          begin a conversion (IDLE only)
//  digit_in       SD2 digit, MSB first
//  digit_valid    digit_in/sign_in valid
//  digit_ready    registered; high throughout RUN
//  sign_in        SD2 running sign, sampled with each digit
//  result         N-bit magnitude, held while result_valid
//  res_sign       SD2 quotient sign (NEG1, POS1 or ZERO_1)
//  result_valid   result/res_sign hold a finished conversion
//  result_ready   consumer takes the result
module intdiv_otf_conv
  import intdiv_otf_conv_pkg::*;
#(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   digit_in,
  input  logic         digit_valid,
  output logic         digit_ready,
  input  logic [1:0]   sign_in,
  output logic [N-1:0] result,
  output logic [1:0]   res_sign,
  output logic         result_valid,
  input  logic         result_ready
);

  localparam int CNT_W = $clog2(N);

  state_e             state_q, state_d;
  logic   [N-1:0]     q, qm;
  logic   [N-1:0]     q_next, qm_next;
  logic   [CNT_W-1:0] cnt;
  logic               accept;
  logic               last;

  assign accept = (state_q == RUN) && digit_valid && digit_ready;
  assign last   = (cnt == CNT_W'(N - 1));

  intdiv_otf_conv_cell #(.N(N)) u_cell (
    .q       (q),
    .qm      (qm),
    .digit   (digit_in),
    .q_next  (q_next),
    .qm_next (qm_next)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)          state_d = RUN;
      RUN:     if (accept && last) state_d = DONE;
      DONE:    if (result_ready)   state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // NOTE: every datapath register has a defined reset value; a reset mid-stream
  // must discard the partial Q/QM and the previous result alike.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q            <= '0;
      qm           <= '1;
      cnt          <= '0;
      digit_ready  <= 1'b0;
      result       <= '0;
      res_sign     <= ZERO_1;
      result_valid <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            q           <= '0;
            qm          <= '1;  // QM = Q - 1 = -1, wraps by design
            cnt         <= '0;
            digit_ready <= 1'b1;
          end
        end
        RUN: begin
          if (accept) begin
            q  <= q_next;
            qm <= qm_next;
            if (last) begin
              // Only the sign travelling with the final digit is ever
              // observed, so it goes straight into res_sign. A zero sign
              // means the whole stream was zero; canonicalise to ZERO_1.
              cnt          <= '0;
              result       <= q_next;
              res_sign     <= sd2_is_zero(sign_in) ? ZERO_1 : sign_in;
              result_valid <= 1'b1;
              digit_ready  <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          if (result_ready) result_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
